llc_snoop_responder: RTL and testbench
======================================

// Module: llc_snoop_responder
// PURPOSE
//  Snoop-side responder of the LLC MESI protocol: answers bus operations issued by other caches.
//  The processor-side read/write handlers act as bus initiators; this block is their counterpart.
//  It looks up the snooped line in the tag/MESI array and drives the snoop result.
//  It moves data out of L1 (GETLINE / INVALIDATELINE), writes back modified lines and updates MESI.
//  PLRU state is never touched.
// PARAMETERS
//  ADDR_W    32  snooped address width
//  INDEX_W   14  set index width = addr[OFF_W+INDEX_W-1:OFF_W]
//  OFF_W      6  byte offset width (64 B line)
//  TAG_W     12  tag width = addr[ADDR_W-1:ADDR_W-TAG_W]; ADDR_W = TAG_W+INDEX_W+OFF_W
//  WAYS      16  associativity; WAY_W = $clog2(WAYS)
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous active-high reset
//  snp_valid     in   1              snoop request valid
//  snp_ready     out  1              block can accept a snoop
//  snp_op        in   3              1=READ 2=WRITE 3=INVALIDATE 4=RWIM (others ignored, NOHIT)
//  snp_addr      in   ADDR_W         snooped address
//  arr_rd_en     out  1              array set read strobe
//  arr_rd_index  out  INDEX_W        set to read
//  arr_rd_tags   in   WAYS*TAG_W     way w tag at [w*TAG_W +: TAG_W]; valid cycle after arr_rd_en
//  arr_rd_mesi   in   WAYS*2         way w MESI at [w*2 +: 2] (M=11 E=10 S=01 I=00)
//  arr_wr_en     out  1              MESI write strobe (one cycle)
//  arr_wr_index  out  INDEX_W        set to write
//  arr_wr_way    out  WAY_W          way to write
//  arr_wr_mesi   out  2              new MESI state
//  l1_msg_valid  out  1              message to L1 valid
//  l1_msg        out  3              1=GETLINE 3=INVALIDATELINE
//  l1_msg_addr   out  ADDR_W         line address, offset bits zero
//  l1_msg_ack    in   1              L1 accepted message
//  wb_valid      out  1              bus WRITE (writeback) request
//  wb_addr       out  ADDR_W         line address, offset bits zero
//  wb_ack        in   1              bus accepted writeback
//  snp_res_valid out  1              one-cycle pulse: snoop result valid
//  snp_res       out  2              00=HIT 01=HITM 10=NOHIT
//  proto_err     out  1              one-cycle pulse: INVALIDATE snooped on E/M line
// BEHAVIOUR
//  Reset: all outputs 0, snp_res=2'b10; FSM->IDLE; an in-flight snoop is abandoned (no array write, no result).
//  FSM: IDLE->LOOKUP->COMPARE->{GETL->}{INVL->}{WRBK->}{UPDATE->}RESPOND->IDLE.
//  IDLE: snp_ready=1; snp_valid&snp_ready latches op/addr. snp_ready=0 in all other states.
//  LOOKUP: arr_rd_en=1 for one cycle. COMPARE: hit = MESI!=I & tag match; lowest matching way wins.
//  Actions by op and state (miss = no hit):
//   READ:  M->S, GETLINE, WRBK, HITM | E->S, HIT | S: no change, HIT | miss: NOHIT
//   RWIM:  M->I, GETLINE, INVALIDATELINE, WRBK, HITM | E/S->I, INVALIDATELINE, HIT | miss: NOHIT
//   INVALIDATE: S->I, INVALIDATELINE, HIT | E/M: no change, proto_err, NOHIT | miss: NOHIT
//   WRITE/other: no change, no messages, NOHIT
//  Order is fixed: GETLINE, INVALIDATELINE, writeback, array write, result.
//  UPDATE runs only if the state changes: arr_wr_en one cycle; index/way come from the COMPARE hit.
//  l1_msg_valid/wb_valid: held with stable payload until their ack is sampled high.
//   The ack may arrive in the first valid cycle. The next request starts no earlier than the following cycle.
//  RESPOND: snp_res_valid=1 exactly one cycle; snp_res stays stable until the next RESPOND.
//  Latency (handshake cycle=T): miss/no-action result at T+3; S-hit READ at T+3; E-hit READ at T+4.
//   Each message/writeback adds >=1 cycle (ack-dependent).
//  Back-to-back: new snoop accepted the cycle after RESPOND (IDLE).
//  proto_err pulses in the RESPOND cycle.
// TESTING
//  Reset mid-WRBK (wb_ack never given), then rst -> no arr_wr_en, no snp_res_valid, snp_ready=1 after release.
//  READ 0x0012_3440, way5 M tag 0x001 -> GETLINE 0x0012_3440, wb 0x0012_3440, way5 ->S, HITM.
//  RWIM same set, way2 S, way9 S same tag -> INVALIDATELINE, way2 ->I only, HIT, no wb.
//  RWIM, way0 M, l1_msg_ack and wb_ack same cycle as valid -> GETLINE, INVALIDATELINE, wb, ->I; HITM at T+7.
//  READ miss (all I or tag mismatch) -> NOHIT at T+3, no msgs. INVALIDATE on E -> proto_err, NOHIT, no write.
//  WRITE snoop on M line -> NOHIT, no change. Two snoops back-to-back -> second accepted in cycle after first RESPOND.

Source files
------------

// File: rtl/llc_snoop_responder.sv
// -----------------------------------------------------------------------------
// llc_snoop_responder
//   Snoop-side responder of the LLC MESI protocol. Accepts one snooped bus
//   operation at a time, reads the addressed set from the tag/MESI array,
//   picks the lowest-numbered valid way whose tag matches, then issues (in
//   fixed order) GETLINE to L1, INVALIDATELINE to L1, a bus writeback, a MESI
//   array write, and finally a one-cycle snoop result. PLRU is never touched.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   snp_valid/snp_ready/snp_op/snp_addr   snoop request handshake
//   arr_rd_en/arr_rd_index          set read strobe (data returns next cycle)
//   arr_rd_tags/arr_rd_mesi         per-way tags and MESI of the read set
//   arr_wr_en/index/way/mesi        single-cycle MESI update
//   l1_msg_valid/l1_msg/l1_msg_addr/l1_msg_ack   GETLINE / INVALIDATELINE
//   wb_valid/wb_addr/wb_ack         writeback of a modified line
//   snp_res_valid/snp_res           result pulse (HIT / HITM / NOHIT)
//   proto_err                       INVALIDATE snooped on an E/M line
// -----------------------------------------------------------------------------
module llc_snoop_responder #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 14,
  parameter int OFF_W   = 6,
  parameter int TAG_W   = 12,
  parameter int WAYS    = 16,
  parameter int WAY_W   = $clog2(WAYS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     snp_valid,
  output logic                     snp_ready,
  input  logic [2:0]               snp_op,
  input  logic [ADDR_W-1:0]        snp_addr,
  output logic                     arr_rd_en,
  output logic [INDEX_W-1:0]       arr_rd_index,
  input  logic [WAYS*TAG_W-1:0]    arr_rd_tags,
  input  logic [WAYS*2-1:0]        arr_rd_mesi,
  output logic                     arr_wr_en,
  output logic [INDEX_W-1:0]       arr_wr_index,
  output logic [WAY_W-1:0]         arr_wr_way,
  output logic [1:0]               arr_wr_mesi,
  output logic                     l1_msg_valid,
  output logic [2:0]               l1_msg,
  output logic [ADDR_W-1:0]        l1_msg_addr,
  input  logic                     l1_msg_ack,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_addr,
  input  logic                     wb_ack,
  output logic                     snp_res_valid,
  output logic [1:0]               snp_res,
  output logic                     proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_GETL, S_INVL, S_WRBK, S_UPDATE, S_RESPOND
  } state_e;

  localparam logic [1:0] MESI_M = 2'b11, MESI_E = 2'b10, MESI_S = 2'b01, MESI_I = 2'b00;
  localparam logic [1:0] RES_HIT = 2'b00, RES_HITM = 2'b01, RES_NOHIT = 2'b10;
  localparam logic [2:0] OP_READ = 3'd1, OP_INVAL = 3'd3, OP_RWIM = 3'd4;
  localparam logic [2:0] MSG_GETLINE = 3'd1, MSG_INVLINE = 3'd3;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  // Everything decided at COMPARE time and replayed by the later states.
  typedef struct packed {
    logic             getl;
    logic             invl;
    logic             wb;
    logic             upd;
    logic             perr;
    logic [1:0]       mesi;   // new MESI state for the hit way
    logic [1:0]       res;
    logic [WAY_W-1:0] way;
  } act_t;

  // First step still required after 'from', in the fixed action order.
  function automatic state_e next_step(input state_e from, input act_t a);
    next_step = S_RESPOND;
    if (a.upd  && (from inside {S_COMPARE, S_GETL, S_INVL, S_WRBK})) next_step = S_UPDATE;
    if (a.wb   && (from inside {S_COMPARE, S_GETL, S_INVL}))         next_step = S_WRBK;
    if (a.invl && (from inside {S_COMPARE, S_GETL}))                 next_step = S_INVL;
    if (a.getl && (from == S_COMPARE))                               next_step = S_GETL;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  act_t                act_q, act_d;
  logic [1:0]          snp_res_q, snp_res_d;

  logic [TAG_W-1:0]    tag_c;
  logic [INDEX_W-1:0]  index_c;
  logic [ADDR_W-1:0]   line_c;
  logic                hit_c;
  logic [WAY_W-1:0]    hit_way_c;
  logic [1:0]          hit_mesi_c;
  act_t                act_c, act_sel;

  assign tag_c   = addr_q[ADDR_W-1 -: TAG_W];
  assign index_c = addr_q[OFF_W +: INDEX_W];
  assign line_c  = addr_q & LINE_MASK;

  // Tag match: lowest valid matching way wins.
  always_comb begin
    // NOTE: every variable gets a value before any condition, so no path can leave it unassigned and infer a latch.
    hit_c      = 1'b0;
    hit_way_c  = '0;
    hit_mesi_c = MESI_I;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_c && arr_rd_mesi[w*2 +: 2] != MESI_I && arr_rd_tags[w*TAG_W +: TAG_W] == tag_c) begin
        hit_c      = 1'b1;
        hit_way_c  = WAY_W'(w);
        hit_mesi_c = arr_rd_mesi[w*2 +: 2];
      end
    end
  end

  // MESI action table for the snooped operation.
  always_comb begin
    act_c      = '0;
    act_c.res  = RES_NOHIT;
    act_c.mesi = hit_mesi_c;
    act_c.way  = hit_way_c;
    if (hit_c) begin
      case (op_q)
        OP_READ: begin
          if (hit_mesi_c == MESI_M) begin
            act_c.getl = 1'b1; act_c.wb = 1'b1; act_c.upd = 1'b1;
            act_c.mesi = MESI_S; act_c.res = RES_HITM;
          end else if (hit_mesi_c == MESI_E) begin
            act_c.upd = 1'b1; act_c.mesi = MESI_S; act_c.res = RES_HIT;
          end else begin
            act_c.res = RES_HIT;
          end
        end
        OP_RWIM: begin
          act_c.invl = 1'b1; act_c.upd = 1'b1; act_c.mesi = MESI_I;
          if (hit_mesi_c == MESI_M) begin
            act_c.getl = 1'b1; act_c.wb = 1'b1; act_c.res = RES_HITM;
          end else begin
            act_c.res = RES_HIT;
          end
        end
        OP_INVAL: begin
          if (hit_mesi_c == MESI_S) begin
            act_c.invl = 1'b1; act_c.upd = 1'b1; act_c.mesi = MESI_I; act_c.res = RES_HIT;
          end else begin
            act_c.perr = 1'b1;  // E/M should never be invalidated by another cache
          end
        end
        default: ;
      endcase
    end
  end

  assign act_sel = (state_q == S_COMPARE) ? act_c : act_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    act_d     = act_q;
    snp_res_d = snp_res_q;

    snp_ready     = (state_q == S_IDLE) && !rst;
    arr_rd_en     = 1'b0;
    arr_rd_index  = '0;
    arr_wr_en     = 1'b0;
    arr_wr_index  = '0;
    arr_wr_way    = '0;
    arr_wr_mesi   = '0;
    l1_msg_valid  = 1'b0;
    l1_msg        = '0;
    l1_msg_addr   = '0;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    snp_res_valid = 1'b0;
    proto_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (snp_valid && snp_ready) begin
          op_d    = snp_op;
          addr_d  = snp_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        arr_rd_en    = 1'b1;
        arr_rd_index = index_c;
        state_d      = S_COMPARE;
      end
      S_COMPARE: begin
        act_d   = act_c;
        state_d = next_step(S_COMPARE, act_c);
      end
      S_GETL: begin
        l1_msg_valid = 1'b1;
        l1_msg       = MSG_GETLINE;
        l1_msg_addr  = line_c;
        if (l1_msg_ack) state_d = next_step(S_GETL, act_q);
      end
      S_INVL: begin
        l1_msg_valid = 1'b1;
        l1_msg       = MSG_INVLINE;
        l1_msg_addr  = line_c;
        if (l1_msg_ack) state_d = next_step(S_INVL, act_q);
      end
      S_WRBK: begin
        wb_valid = 1'b1;
        wb_addr  = line_c;
        if (wb_ack) state_d = next_step(S_WRBK, act_q);
      end
      S_UPDATE: begin
        arr_wr_en    = 1'b1;
        arr_wr_index = index_c;
        arr_wr_way   = act_q.way;
        arr_wr_mesi  = act_q.mesi;
        state_d      = S_RESPOND;
      end
      S_RESPOND: begin
        snp_res_valid = 1'b1;
        proto_err     = act_q.perr;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The visible result changes only when entering RESPOND, then holds.
    if (state_d == S_RESPOND) snp_res_d = act_sel.res;
  end

  assign snp_res = snp_res_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      act_q     <= '0;
      snp_res_q <= RES_NOHIT;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      act_q     <= act_d;
      snp_res_q <= snp_res_d;
    end
  end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// -----------------------------------------------------------------------------
// tb_llc_snoop_responder
//   Self-checking bench: a behavioural tag/MESI array answers the DUT's set
//   reads and absorbs its writes; a table-driven MESI model predicts the
//   event sequence, result, latency and array update for each snoop.
// -----------------------------------------------------------------------------
module tb_llc_snoop_responder;

  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 14;
  localparam int OFF_W   = 6;
  localparam int TAG_W   = 12;
  localparam int WAYS    = 16;
  localparam int WAY_W   = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  snp_valid;
  logic                  snp_ready;
  logic [2:0]            snp_op;
  logic [ADDR_W-1:0]     snp_addr;
  logic                  arr_rd_en;
  logic [INDEX_W-1:0]    arr_rd_index;
  logic [WAYS*TAG_W-1:0] arr_rd_tags = '0;
  logic [WAYS*2-1:0]     arr_rd_mesi = '0;
  logic                  arr_wr_en;
  logic [INDEX_W-1:0]    arr_wr_index;
  logic [WAY_W-1:0]      arr_wr_way;
  logic [1:0]            arr_wr_mesi;
  logic                  l1_msg_valid;
  logic [2:0]            l1_msg;
  logic [ADDR_W-1:0]     l1_msg_addr;
  logic                  l1_msg_ack;
  logic                  wb_valid;
  logic [ADDR_W-1:0]     wb_addr;
  logic                  wb_ack;
  logic                  snp_res_valid;
  logic [1:0]            snp_res;
  logic                  proto_err;

  always #5 clk = ~clk;

  llc_snoop_responder dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .arr_rd_en(arr_rd_en), .arr_rd_index(arr_rd_index),
    .arr_rd_tags(arr_rd_tags), .arr_rd_mesi(arr_rd_mesi),
    .arr_wr_en(arr_wr_en), .arr_wr_index(arr_wr_index), .arr_wr_way(arr_wr_way), .arr_wr_mesi(arr_wr_mesi),
    .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr), .l1_msg_ack(l1_msg_ack),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .snp_res_valid(snp_res_valid), .snp_res(snp_res), .proto_err(proto_err)
  );

  // Behavioural tag/MESI array, one packed row per set.
  logic [WAYS*TAG_W-1:0] mem_tags [logic [INDEX_W-1:0]];
  logic [WAYS*2-1:0]     mem_mesi [logic [INDEX_W-1:0]];

  always @(posedge clk) begin
    if (arr_rd_en) begin
      if (mem_tags.exists(arr_rd_index)) begin
        arr_rd_tags <= mem_tags[arr_rd_index];
        arr_rd_mesi <= mem_mesi[arr_rd_index];
      end else begin
        arr_rd_tags <= '0;
        arr_rd_mesi <= '0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_set(input logic [INDEX_W-1:0] idx);
    mem_tags[idx] = '0;
    mem_mesi[idx] = '0;
  endtask

  task automatic set_way(input logic [INDEX_W-1:0] idx, input int way,
                         input logic [TAG_W-1:0] tag, input logic [1:0] mesi);
    logic [WAYS*TAG_W-1:0] t;
    logic [WAYS*2-1:0]     m;
    if (!mem_tags.exists(idx)) clear_set(idx);
    t = mem_tags[idx];
    m = mem_mesi[idx];
    t[way*TAG_W +: TAG_W] = tag;
    m[way*2 +: 2]         = mesi;
    mem_tags[idx] = t;
    mem_mesi[idx] = m;
  endtask

  function automatic logic [1:0] get_mesi(input logic [INDEX_W-1:0] idx, input int way);
    logic [WAYS*2-1:0] m;
    if (!mem_mesi.exists(idx)) return 2'b00;
    m = mem_mesi[idx];
    return m[way*2 +: 2];
  endfunction

  // Outcome of the last snoop, for directed follow-up checks.
  int         last_lat;
  logic [1:0] last_res;

  task automatic run_snoop(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                           input int d_l1, input int d_wb);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  line;
    logic [WAYS*TAG_W-1:0] trow;
    logic [WAYS*2-1:0]     mrow;
    bit   hit, e_getl, e_invl, e_wb, e_upd, e_perr;
    logic [1:0] m, e_mesi, e_res;
    int   e_way, e_lat, lat, rd_n, l1_wait, wb_wait, stray_perr;
    logic [63:0] e_ev, ev;
    bit   done, perr_seen;
    logic [1:0] res;

    idx  = addr[OFF_W +: INDEX_W];
    tag  = addr[ADDR_W-1 -: TAG_W];
    line = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    if (!mem_tags.exists(idx)) clear_set(idx);
    trow = mem_tags[idx];
    mrow = mem_mesi[idx];

    // Reference model: lowest valid matching way, then the MESI table.
    hit = 0; e_way = 0; m = 2'b00;
    for (int w = WAYS-1; w >= 0; w--)
      if (mrow[w*2 +: 2] != 2'b00 && trow[w*TAG_W +: TAG_W] == tag) begin
        hit = 1; e_way = w; m = mrow[w*2 +: 2];
      end
    {e_getl, e_invl, e_wb, e_upd, e_perr} = '0;
    e_mesi = m; e_res = 2'b10;
    if (hit) begin
      case (op)
        3'd1: if (m == 2'b11) begin e_getl = 1; e_wb = 1; e_upd = 1; e_mesi = 2'b01; e_res = 2'b01; end
              else if (m == 2'b10) begin e_upd = 1; e_mesi = 2'b01; e_res = 2'b00; end
              else e_res = 2'b00;
        3'd4: begin
                e_invl = 1; e_upd = 1; e_mesi = 2'b00;
                e_getl = (m == 2'b11); e_wb = (m == 2'b11);
                e_res  = (m == 2'b11) ? 2'b01 : 2'b00;
              end
        3'd3: if (m == 2'b01) begin e_invl = 1; e_upd = 1; e_mesi = 2'b00; e_res = 2'b00; end
              else e_perr = 1;
        default: ;
      endcase
    end
    e_ev = 0;
    if (e_getl) e_ev = e_ev*8 + 1;
    if (e_invl) e_ev = e_ev*8 + 3;
    if (e_wb)   e_ev = e_ev*8 + 5;
    if (e_upd)  e_ev = e_ev*8 + 6;
    e_ev  = e_ev*8 + 7;
    e_lat = 3 + (e_getl ? d_l1+1 : 0) + (e_invl ? d_l1+1 : 0) + (e_wb ? d_wb+1 : 0) + (e_upd ? 1 : 0);

    // Drive the request; we are at a negedge.
    check("snp_ready", snp_ready, 1);
    snp_valid = 1; snp_op = op; snp_addr = addr;
    @(posedge clk);
    done = 0; ev = 0; lat = 0; rd_n = 0; l1_wait = 0; wb_wait = 0; stray_perr = 0;
    perr_seen = 0; res = 2'b11;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      snp_valid = 0; l1_msg_ack = 0; wb_ack = 0;
      if (arr_rd_en) begin
        rd_n = n;
        check("rd_index", arr_rd_index, idx);
      end
      if (l1_msg_valid) begin
        check("l1_addr", l1_msg_addr, line);
        l1_wait++;
        if (l1_wait > d_l1) begin l1_msg_ack = 1; l1_wait = 0; ev = ev*8 + l1_msg; end
      end
      if (wb_valid) begin
        check("wb_addr", wb_addr, line);
        wb_wait++;
        if (wb_wait > d_wb) begin wb_ack = 1; wb_wait = 0; ev = ev*8 + 5; end
      end
      if (arr_wr_en) begin
        check("wr_index", arr_wr_index, idx);
        check("wr_way", arr_wr_way, e_way);
        check("wr_mesi", arr_wr_mesi, e_mesi);
        ev = ev*8 + 6;
        if (mem_mesi.exists(arr_wr_index)) begin
          mrow = mem_mesi[arr_wr_index];
          mrow[arr_wr_way*2 +: 2] = arr_wr_mesi;
          mem_mesi[arr_wr_index] = mrow;
        end
      end
      if (proto_err && !snp_res_valid) stray_perr++;
      if (snp_res_valid) begin
        ev = ev*8 + 7; lat = n; done = 1; res = snp_res; perr_seen = proto_err;
      end
    end
    check("res_timeout", done, 1);
    check("rd_cycle", rd_n, 1);
    check("event_seq", ev, e_ev);
    check("latency", lat, e_lat);
    check("snp_res", res, e_res);
    check("proto_err", perr_seen, e_perr);
    check("stray_perr", stray_perr, 0);
    last_lat = lat; last_res = res;
    l1_msg_ack = 0; wb_ack = 0;
    @(negedge clk);
    check("res_pulse", snp_res_valid, 0);
    check("res_hold", snp_res, e_res);
  endtask

  task automatic reset_mid_wrbk(input logic [ADDR_W-1:0] addr);
    bit seen;
    int bad;
    check("snp_ready", snp_ready, 1);
    snp_valid = 1; snp_op = 3'd1; snp_addr = addr;
    @(posedge clk);
    seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      snp_valid = 0; wb_ack = 0;
      l1_msg_ack = l1_msg_valid;
      if (wb_valid) seen = 1;
    end
    check("rst_reach_wrbk", seen, 1);
    l1_msg_ack = 0;
    rst = 1; bad = 0;
    repeat (2) begin
      @(negedge clk);
      bad += int'(arr_wr_en | snp_res_valid);
    end
    check("rst_hold_ready", snp_ready, 0);
    check("rst_hold_wb", wb_valid, 0);
    check("rst_hold_res", snp_res, 2'b10);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      bad += int'(arr_wr_en | snp_res_valid | wb_valid | l1_msg_valid);
    end
    check("rst_abandon", bad, 0);
    check("rst_ready_after", snp_ready, 1);
  endtask

  localparam logic [ADDR_W-1:0] A0 = 32'h0012_3440;
  localparam logic [INDEX_W-1:0] IDX0 = 14'h08D1;

  initial begin
    logic [INDEX_W-1:0] sets [4];
    logic [TAG_W-1:0]   tags [3];
    sets[0] = IDX0; sets[1] = 14'h0000; sets[2] = 14'h3FFF; sets[3] = 14'h1234;
    tags[0] = 12'h001; tags[1] = 12'h002; tags[2] = 12'h003;

    rst = 1; snp_valid = 0; snp_op = '0; snp_addr = '0; l1_msg_ack = 0; wb_ack = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", snp_ready, 0);
    check("reset_res", snp_res, 2'b10);
    check("reset_res_valid", snp_res_valid, 0);
    check("reset_outs", {arr_rd_en, arr_wr_en, l1_msg_valid, wb_valid, proto_err}, 0);
    rst = 0;
    @(negedge clk);
    check("ready_after_reset", snp_ready, 1);

    // Modified line, reset while the writeback is pending.
    clear_set(IDX0);
    set_way(IDX0, 5, 12'h001, 2'b11);
    reset_mid_wrbk(A0);
    check("rst_line_untouched", get_mesi(IDX0, 5), 2'b11);

    // READ on M: GETLINE, writeback, M->S, HITM.
    run_snoop(3'd1, A0, 0, 0);
    check("read_m_res", last_res, 2'b01);
    check("read_m_now_s", get_mesi(IDX0, 5), 2'b01);

    // RWIM with two S ways of the same tag: only the lowest is invalidated.
    set_way(IDX0, 2, 12'h055, 2'b01);
    set_way(IDX0, 9, 12'h055, 2'b01);
    run_snoop(3'd4, {12'h055, IDX0, 6'h00}, 1, 0);
    check("rwim_s_way2", get_mesi(IDX0, 2), 2'b00);
    check("rwim_s_way9", get_mesi(IDX0, 9), 2'b01);

    // RWIM on M with immediate acks: result seven cycles after the handshake.
    set_way(IDX0, 0, 12'h0AA, 2'b11);
    run_snoop(3'd4, {12'h0AA, IDX0, 6'h11}, 0, 0);
    check("rwim_m_lat", last_lat, 7);
    check("rwim_m_way0", get_mesi(IDX0, 0), 2'b00);

    // Miss, INVALIDATE on E, WRITE on M, E and S READ hits.
    run_snoop(3'd1, {12'h3FF, IDX0, 6'h00}, 0, 0);
    check("miss_lat", last_lat, 3);
    set_way(IDX0, 3, 12'h0BB, 2'b10);
    run_snoop(3'd3, {12'h0BB, IDX0, 6'h00}, 0, 0);
    check("inval_e_kept", get_mesi(IDX0, 3), 2'b10);
    set_way(IDX0, 4, 12'h0CC, 2'b11);
    run_snoop(3'd2, {12'h0CC, IDX0, 6'h00}, 0, 0);
    check("write_m_kept", get_mesi(IDX0, 4), 2'b11);
    set_way(IDX0, 6, 12'h0DD, 2'b10);
    run_snoop(3'd1, {12'h0DD, IDX0, 6'h00}, 0, 0);
    check("read_e_lat", last_lat, 4);
    run_snoop(3'd1, {12'h055, IDX0, 6'h00}, 2, 2);
    check("read_s_lat", last_lat, 3);

    // Randomized snoops over a few sets and a small tag pool.
    for (int s = 0; s < 4; s++) begin
      clear_set(sets[s]);
      for (int w = 0; w < WAYS; w++)
        set_way(sets[s], w, tags[$urandom_range(0, 2)], 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 300; i++) begin
      logic [INDEX_W-1:0] idx;
      idx = sets[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0)
        set_way(idx, $urandom_range(0, WAYS-1), tags[$urandom_range(0, 2)], 2'($urandom_range(0, 3)));
      run_snoop(3'($urandom_range(0, 7)),
                {tags[$urandom_range(0, 2)], idx, 6'($urandom_range(0, 63))},
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
